// File: rtl/egress_header_rewrite.sv
// rtl/egress_header_rewrite.sv - egress source MAC rewrite, IPv4 TTL decrement/checksum update, TTL-expired drop
module egress_header_rewrite #(
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DST_PORT_POS         = 24
) (
    input  logic                              AXI_ACLK,
    input  logic                              AXI_RESETN,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic                              S_AXIS_TLAST,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TLAST,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]     reset,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac0_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac0_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac1_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac1_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac2_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac2_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac3_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac3_high,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     rewritten_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ttl_expired_count
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int SW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int FW    = 1 + UW + SW + DW;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = C_S_AXI_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Input FIFO: fallthrough, head word visible combinationally.
    logic [FW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          nearly_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [FW-1:0] head;
    logic [DW-1:0] head_data;
    logic [SW-1:0] head_strb;
    logic [UW-1:0] head_user;
    logic          head_last;

    logic [47:0]   port_mac_tbl [4];
    logic [47:0]   port_mac;
    logic          port_hit;
    logic          is_ipv4;
    logic [7:0]    head_ttl;
    logic          ttl_expired;
    logic [16:0]   csum_sum;
    logic [DW-1:0] first_data;

    state_t        state_q, state_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic [SW-1:0] m_strb_q, m_strb_d;
    logic [UW-1:0] m_user_q, m_user_d;
    logic          m_last_q, m_last_d;
    logic [CW-1:0] rw_cnt_q, rw_cnt_d;
    logic [CW-1:0] ttl_cnt_q, ttl_cnt_d;

    logic          out_load;
    logic          fwd;
    logic          use_first;
    logic          rw_inc;
    logic          ttl_inc;
    logic          cnt_clear;
    logic          unused_mac_high;

    assign nearly_full   = count_q >= (AW+1)'(DEPTH - 1);
    assign fifo_empty    = count_q == '0;
    assign S_AXIS_TREADY = !nearly_full;
    assign push          = S_AXIS_TVALID && !nearly_full;

    assign head      = fifo_mem[rd_ptr_q];
    assign head_data = head[DW-1:0];
    assign head_strb = head[DW+SW-1:DW];
    assign head_user = head[DW+SW+UW-1:DW+SW];
    assign head_last = head[FW-1];

    assign port_mac_tbl[0] = {mac0_high[15:0], mac0_low};
    assign port_mac_tbl[1] = {mac1_high[15:0], mac1_low};
    assign port_mac_tbl[2] = {mac2_high[15:0], mac2_low};
    assign port_mac_tbl[3] = {mac3_high[15:0], mac3_low};

    assign unused_mac_high = ^{mac0_high[CW-1:16], mac1_high[CW-1:16],
                               mac2_high[CW-1:16], mac3_high[CW-1:16]};

    // Lowest-numbered MAC port wins when several dest bits are set.
    always_comb begin
        port_hit = 1'b0;
        port_mac = '0;
        for (int i = 3; i >= 0; i--) begin
            if (head_user[DST_PORT_POS + 2*i]) begin
                port_hit = 1'b1;
                port_mac = port_mac_tbl[i];
            end
        end
    end

    assign is_ipv4     = port_hit && (head_data[159:144] == 16'h0800);
    assign head_ttl    = head_data[79:72];
    assign ttl_expired = is_ipv4 && (head_ttl <= 8'd1);
    assign csum_sum    = {1'b0, head_data[63:48]} + 17'h00100;

    // TTL drops by one in the high byte of its 16-bit word, so the stored
    // ones-complement checksum rises by 0x0100 with end-around carry.
    always_comb begin
        first_data = head_data;
        if (port_hit) begin
            first_data[207:160] = port_mac;
        end
        if (is_ipv4) begin
            first_data[79:72] = head_ttl - 8'd1;
            first_data[63:48] = csum_sum[15:0] + {15'd0, csum_sum[16]};
        end
    end

    assign out_load  = !m_valid_q || M_AXIS_TREADY;
    assign cnt_clear = reset == CW'(1);

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        fwd       = 1'b0;
        use_first = 1'b0;
        rw_inc    = 1'b0;
        ttl_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (ttl_expired) begin
                        pop     = 1'b1;
                        ttl_inc = 1'b1;
                        if (!head_last) state_d = ST_DROP;
                    end else if (out_load) begin
                        pop       = 1'b1;
                        fwd       = 1'b1;
                        use_first = 1'b1;
                        rw_inc    = port_hit;
                        if (!head_last) state_d = ST_PASS;
                    end
                end
            end
            ST_PASS: begin
                if (!fifo_empty && out_load) begin
                    pop = 1'b1;
                    fwd = 1'b1;
                    if (head_last) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_strb_d  = m_strb_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
        if (out_load) begin
            m_valid_d = fwd;
            if (fwd) begin
                m_data_d = use_first ? first_data : head_data;
                m_strb_d = head_strb;
                m_user_d = head_user;
                m_last_d = head_last;
            end
        end

        rw_cnt_d  = rw_cnt_q + CW'(rw_inc);
        ttl_cnt_d = ttl_cnt_q + CW'(ttl_inc);
        if (cnt_clear) begin
            rw_cnt_d  = '0;
            ttl_cnt_d = '0;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_strb_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
            rw_cnt_q  <= '0;
            ttl_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_strb_q  <= m_strb_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
            rw_cnt_q  <= rw_cnt_d;
            ttl_cnt_q <= ttl_cnt_d;
        end
    end

    assign M_AXIS_TVALID     = m_valid_q;
    assign M_AXIS_TDATA      = m_data_q;
    assign M_AXIS_TSTRB      = m_strb_q;
    assign M_AXIS_TUSER      = m_user_q;
    assign M_AXIS_TLAST      = m_last_q;
    assign rewritten_count   = rw_cnt_q;
    assign ttl_expired_count = ttl_cnt_q;

endmodule
